// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request side and a valid/ready
// result side. Most operations finish in one cycle. MULTU, and DIVU when
// the divider is built, iterate one bit per cycle.
//
// Optional divider: define SEQ_ALU_DIV_EN to build DIVU.
// Without it, opcode 1101 behaves like any other undefined opcode.
//
// Handshake: a request is taken on a rising edge where in_valid & in_ready.
// A result is presented while out_valid is high and is held unchanged until
// a rising edge where out_valid & out_ready. in_ready is high only in IDLE,
// so a result can never be consumed and a new request accepted in the same cycle.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_control,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   hi,
  output logic               zero,
  output logic               overflow,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_NOR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic               accept;
  logic               start_mul, start_div;
  logic [WIDTH-1:0]   sc_result, sc_hi;
  logic               sc_ovf;
  logic [WIDTH-1:0]   sum_ab, diff_ab;

  // Iteration registers: op_b is the fixed operand (multiplicand or divisor),
  // work_hi/work_lo hold the partial product or remainder/quotient.
  logic [WIDTH-1:0]   op_b, work_hi, work_lo;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH:0]     mul_sum;

  logic [WIDTH-1:0]   result_q, hi_q;
  logic               zero_q, ovf_q;

`ifdef SEQ_ALU_DIV_EN
  logic               op_is_mul;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
`endif

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign dbg_state = state;

  assign sum_ab  = a + b;
  assign diff_ab = a - b;

  // Classify the incoming opcode as iterative or single-cycle.
  always_comb begin
    start_mul = (alu_control == OP_MULTU);
`ifdef SEQ_ALU_DIV_EN
    start_div = (alu_control == OP_DIVU) && (b != '0);
`else
    start_div = 1'b0;
`endif
  end

  // Single-cycle result from the live inputs; it is registered on the accept edge.
  always_comb begin
    sc_result = '0;
    sc_hi     = '0;
    sc_ovf    = 1'b0;
    case (alu_control)
      OP_AND:  sc_result = a & b;
      OP_NOR:  sc_result = ~(a | b);
      OP_OR:   sc_result = a | b;
      OP_ADD: begin
        sc_result = sum_ab;
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff_ab;
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_result = a << shamt;
      OP_SRL:  sc_result = a >> shamt;
      OP_SRA:  sc_result = $unsigned($signed(a) >>> shamt);
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU: begin
        // Only reached here with b == 0; b != 0 takes the iterative path.
        sc_result = '1;
        sc_hi     = a;
      end
`endif
      default: begin
        sc_result = '0;
        sc_hi     = '0;
      end
    endcase
  end

  // One iteration step: shift-add multiply or, if built, a restoring divide.
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
`ifdef SEQ_ALU_DIV_EN
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, op_b});
    div_diff  = div_shift[WIDTH-1:0] - op_b;
    if (op_is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], div_ge};
    end
`else
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
`endif
  end

  // Control FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (start_mul || start_div) ? BUSY : DONE;
      BUSY: if (count == LAST_STEP) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_b     <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      count    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      op_is_mul <= 1'b0;
`endif
    end else if (accept) begin
      count   <= '0;
      work_hi <= '0;
      if (start_mul) begin
        op_b    <= a;
        work_lo <= b;
      end else begin
        op_b    <= b;
        work_lo <= a;
      end
`ifdef SEQ_ALU_DIV_EN
      op_is_mul <= start_mul;
`endif
      if (!(start_mul || start_div)) begin
        result_q <= sc_result;
        hi_q     <= sc_hi;
        zero_q   <= (sc_result == '0);
        ovf_q    <= sc_ovf;
      end
    end else if (state == BUSY) begin
      work_hi <= step_hi;
      work_lo <= step_lo;
      if (count == LAST_STEP) begin
        // The last step lands straight in the result registers so DONE
        // starts exactly WIDTH cycles after BUSY was entered.
        count    <= '0;
        result_q <= step_lo;
        hi_q     <= step_hi;
        zero_q   <= (step_lo == '0);
        ovf_q    <= 1'b0;
      end else begin
        count <= count + SHAMT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=32) with hand-computed expectations.
module tb_seq_alu;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  alu_control;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result, hi;
  logic        zero, overflow;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .hi(hi), .zero(zero), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for out_valid; lat counts cycles from accept.
  // Inputs are scrambled right after accept to confirm they were captured.
  task automatic run_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input logic [4:0] sh, output int lat, output int busy_ready);
    int w;
    lat = 0;
    busy_ready = 0;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("wait_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid    = 1'b1;
    alu_control = op;
    a           = va;
    b           = vb;
    shamt       = sh;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    a           = 32'h5A5A_1234;
    b           = 32'hDEAD_BEEF;
    shamt       = 5'd17;
    alu_control = 4'b0010;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) busy_ready++;
    end
    if (!out_valid) check("timeout_out_valid", 64'd0, 64'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin : main
    int lat, br, late, unstable;
    logic [31:0] held;
    in_valid = 0; out_ready = 0; a = 0; b = 0; alu_control = 0; shamt = 0;
    reset_n = 0;
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // ADD with signed overflow
    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, lat, br);
    check("add_lat", lat, 1);
    check("add_result", {32'd0, result}, 64'h8000_0000);
    check("add_ovf", {63'd0, overflow}, 64'd1);
    check("add_zero", {63'd0, zero}, 64'd0);
    check("add_hi", {32'd0, hi}, 64'd0);
    // Hold out_ready low for 10 cycles in DONE
    held = result;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== held || overflow !== 1'b1) unstable++;
    end
    check("hold_stable", unstable, 0);
    consume();
    check("after_consume_valid", {63'd0, out_valid}, 64'd0);
    check("after_consume_ready", {63'd0, in_ready}, 64'd1);

    run_op(4'b0110, 32'd5, 32'd5, 5'd0, lat, br);
    check("sub_result", {32'd0, result}, 64'd0);
    check("sub_zero", {63'd0, zero}, 64'd1);
    check("sub_ovf", {63'd0, overflow}, 64'd0);
    consume();

    run_op(4'b0110, 32'h8000_0000, 32'd1, 5'd0, lat, br);
    check("subov_result", {32'd0, result}, 64'h7FFF_FFFF);
    check("subov_ovf", {63'd0, overflow}, 64'd1);
    consume();

    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, br);
    check("slt_result", {32'd0, result}, 64'd1);
    consume();
    run_op(4'b1011, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, br);
    check("sltu_result", {32'd0, result}, 64'd0);
    check("sltu_zero", {63'd0, zero}, 64'd1);
    consume();

    run_op(4'b1010, 32'h8000_0000, 32'd0, 5'd4, lat, br);
    check("sra_result", {32'd0, result}, 64'hF800_0000);
    consume();
    run_op(4'b1001, 32'h8000_0000, 32'd0, 5'd4, lat, br);
    check("srl_result", {32'd0, result}, 64'h0800_0000);
    consume();
    run_op(4'b1000, 32'd4, 32'd0, 5'd3, lat, br);
    check("sll_result", {32'd0, result}, 64'd32);
    consume();
    run_op(4'b1000, 32'd1, 32'd0, 5'd31, lat, br);
    check("sll31_result", {32'd0, result}, 64'h8000_0000);
    consume();

    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, br);
    check("and_result", {32'd0, result}, 64'hF000_F000);
    consume();
    run_op(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, br);
    check("or_result", {32'd0, result}, 64'hFFF0_FFF0);
    consume();
    run_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, br);
    check("nor_result", {32'd0, result}, 64'h000F_000F);
    consume();

    run_op(4'b0100, 32'h1234, 32'h5678, 5'd0, lat, br);
    check("undef_lat", lat, 1);
    check("undef_result", {32'd0, result}, 64'd0);
    check("undef_zero", {63'd0, zero}, 64'd1);
    consume();

    // Iterative multiply
    run_op(4'b1100, 32'hFFFF_FFFF, 32'd2, 5'd0, lat, br);
    check("mul_lat", lat, 33);
    check("mul_busy_ready", br, 0);
    check("mul_hi", {32'd0, hi}, 64'd1);
    check("mul_result", {32'd0, result}, 64'hFFFF_FFFE);
    check("mul_ovf", {63'd0, overflow}, 64'd0);
    consume();
    run_op(4'b1100, 32'h0001_0000, 32'h0001_0000, 5'd0, lat, br);
    check("mul2_hi", {32'd0, hi}, 64'd1);
    check("mul2_result", {32'd0, result}, 64'd0);
    check("mul2_zero", {63'd0, zero}, 64'd1);
    consume();
    run_op(4'b1100, 32'd3, 32'd5, 5'd0, lat, br);
    check("mul3_result", {32'd0, result}, 64'd15);
    check("mul3_hi", {32'd0, hi}, 64'd0);
    consume();

`ifdef SEQ_ALU_DIV_EN
    run_op(4'b1101, 32'd100, 32'd7, 5'd0, lat, br);
    check("div_lat", lat, 33);
    check("div_result", {32'd0, result}, 64'd14);
    check("div_hi", {32'd0, hi}, 64'd2);
    consume();
    run_op(4'b1101, 32'd100, 32'd0, 5'd0, lat, br);
    check("div0_lat", lat, 1);
    check("div0_result", {32'd0, result}, 64'hFFFF_FFFF);
    check("div0_hi", {32'd0, hi}, 64'd100);
    consume();
`else
    run_op(4'b1101, 32'd100, 32'd7, 5'd0, lat, br);
    check("divx_lat", lat, 1);
    check("divx_result", {32'd0, result}, 64'd0);
    check("divx_hi", {32'd0, hi}, 64'd0);
    check("divx_zero", {63'd0, zero}, 64'd1);
    consume();
`endif

    // Reset in the middle of a multiply abandons it.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'b1100; a = 32'd7; b = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstmid_in_ready", {63'd0, in_ready}, 64'd1);
    check("rstmid_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    late = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) late++;
    end
    check("rstmid_no_late", late, 0);

    // Block still usable after reset.
    run_op(4'b0010, 32'd2, 32'd3, 5'd0, lat, br);
    check("post_rst_add", {32'd0, result}, 64'd5);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 Parameter: SHAMT_W, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: alu_control  input  4  operation code.
REQ-010 Port: shamt  input  SHAMT_W  shift amount.
REQ-011 Port: out_valid  output  1  result available.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: result  output  WIDTH  primary result (product low half / quotient).
REQ-014 Port: hi  output  WIDTH  product high half / remainder; 0 for other ops.
REQ-015 Port: zero  output  1  result == 0.
REQ-016 Port: overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.

Function
REQ-017 Opcodes: AND 0000, NOR 0001, ADD 0010, OR 0011, SUB 0110, SLT 0111 (signed), SLL 1000, SRL 1001, SRA 1010, SLTU 1011, MULTU 1100, DIVU 1101; all others undefined.
REQ-018 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019 Accept = in_valid & in_ready; operands and opcode captured on accept edge; later input changes ignored until next accept.
REQ-020 Single-cycle ops and undefined codes: IDLE->DONE on accept; out_valid high on next cycle (latency 1).
REQ-021 Undefined code: result=0, hi=0, zero=1, overflow=0.
REQ-022 Shifts use captured shamt (0..WIDTH-1); SRA replicates a[WIDTH-1].
REQ-023 ADD/SUB wrap modulo 2^WIDTH; overflow = signed overflow of the operation.
REQ-024 MULTU: iterative shift-add, one bit per cycle; IDLE->BUSY on accept, BUSY for exactly WIDTH cycles, then DONE; out_valid rises WIDTH+1 cycles after accept; {hi,result} = unsigned 2*WIDTH-bit product.
REQ-025 DIVU (b!=0): restoring division, same timing as MULTU; result=quotient, hi=remainder.
REQ-026 DIVU with b==0: IDLE->DONE directly (latency 1); result=all ones, hi=a.
REQ-027 DONE: result, hi, zero, overflow, out_valid held stable until out_valid & out_ready; then DONE->IDLE next edge.
REQ-028 New request cannot be accepted in the same cycle a result is consumed (minimum 2 cycles between accepts).
REQ-029 zero and overflow SHALL be registered together with result; outputs SHALL NOT change in IDLE/BUSY except as in REQ-030.
REQ-030 In BUSY, out_valid=0; result/hi/zero/overflow hold the previous completed values.

Reset
REQ-031 reset_n low: asynchronously FSM->IDLE, out_valid=0, result=0, hi=0, zero=0, overflow=0, iteration counter=0.
REQ-032 Reset asserted in BUSY or DONE SHALL abandon the operation; no result delivered after release.
REQ-033 First accept possible on first rising edge after reset_n deasserts (in_ready=1 during reset).

Configuration
REQ-034 Macro SEQ_ALU_DIV_EN: when defined, DIVU implemented per REQ-025/026.
REQ-035 When SEQ_ALU_DIV_EN undefined: no divider logic; 1101 treated as undefined code per REQ-021 (latency 1).

Verification
REQ-036 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> 1 cycle later out_valid=1, result=0x80000000, overflow=1, zero=0.
REQ-037 SUB a=5 b=5 -> result=0, zero=1; SLT a=0xFFFFFFFF b=1 -> result=1; SLTU same operands -> result=0.
REQ-038 SRA a=0x80000000 shamt=4 -> result=0xF8000000; SLL a=4 shamt=3 -> result=32.
REQ-039 MULTU a=0xFFFFFFFF b=2 -> out_valid exactly 33 cycles after accept, hi=1, result=0xFFFFFFFE; in_ready=0 throughout.
REQ-040 DIVU a=100 b=7 -> 33-cycle latency, result=14, hi=2; b=0 -> latency 1, result=0xFFFFFFFF, hi=100; without SEQ_ALU_DIV_EN -> result=0, zero=1.
REQ-041 Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; assert reset_n=0 mid-MULTU -> out_valid=0 immediately, in_ready=1, no late result.
